// File: rtl/rtc_bus_sequencer.sv
// RTC multiplexed-bus sequencer: sweeps the seconds/minutes/hours registers,
// reading into held outputs or writing from a snapshot taken at start.
module rtc_bus_sequencer #(
    parameter int         T_PH      = 4,
    parameter logic [7:0] ADDR_SEG  = 8'h21,
    parameter logic [7:0] ADDR_MIN  = 8'h22,
    parameter logic [7:0] ADDR_HORA = 8'h23
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_read,
    input  logic       start_write,
    input  logic [7:0] seg_in,
    input  logic [7:0] min_in,
    input  logic [7:0] hora_in,
    input  logic [7:0] bus_in,
    output logic [7:0] bus_out,
    output logic       bus_oe,
    output logic       cs_n,
    output logic       rd_n,
    output logic       wr_n,
    output logic       ad_n,
    output logic [7:0] seg_out,
    output logic [7:0] min_out,
    output logic [7:0] hora_out,
    output logic       busy,
    output logic       done
);

    localparam int PW = $clog2(T_PH) + 1;
    localparam logic [PW-1:0] PH_LAST = PW'(T_PH - 1);

    typedef enum logic [2:0] {IDLE, ADDR, GAP1, DATA, GAP2, DONE} state_t;

    state_t          state, state_d;
    logic [PW-1:0]   ph, ph_d;
    logic [1:0]      idx, idx_d;
    logic            mode_wr, mode_wr_d;
    logic [2:0][7:0] snap, snap_d;
    logic            phase_end, capture;
    logic [7:0]      addr_sel, data_sel;
    logic [7:0]      bus_out_d;
    logic            bus_oe_d, cs_n_d, rd_n_d, wr_n_d, ad_n_d;
    logic            busy_d, done_d;

    always_comb begin
        state_d   = state;
        ph_d      = ph;
        idx_d     = idx;
        mode_wr_d = mode_wr;
        snap_d    = snap;
        phase_end = (ph == PH_LAST);
        capture   = (state == DATA) && !mode_wr && phase_end;
        unique case (state)
            IDLE: begin
                ph_d  = '0;
                idx_d = 2'd0;
                if (start_write) begin
                    state_d   = ADDR;
                    mode_wr_d = 1'b1;
                    snap_d    = {hora_in, min_in, seg_in};
                end else if (start_read) begin
                    state_d   = ADDR;
                    mode_wr_d = 1'b0;
                end
            end
            ADDR, GAP1, DATA, GAP2: begin
                ph_d = phase_end ? '0 : ph + 1'b1;
                if (phase_end) begin
                    unique case (state)
                        ADDR: state_d = GAP1;
                        GAP1: state_d = DATA;
                        DATA: state_d = GAP2;
                        default: begin
                            if (idx == 2'd2) begin
                                state_d = DONE;
                            end else begin
                                state_d = ADDR;
                                idx_d   = idx + 2'd1;
                            end
                        end
                    endcase
                end
            end
            DONE: begin
                state_d = IDLE;
                idx_d   = 2'd0;
            end
            default: state_d = IDLE;
        endcase

        unique case (idx_d)
            2'd0: begin
                addr_sel = ADDR_SEG;
                data_sel = snap_d[0];
            end
            2'd1: begin
                addr_sel = ADDR_MIN;
                data_sel = snap_d[1];
            end
            default: begin
                addr_sel = ADDR_HORA;
                data_sel = snap_d[2];
            end
        endcase

        // Outputs are decoded from the next state so they can be registered.
        bus_out_d = bus_out;
        bus_oe_d  = 1'b0;
        cs_n_d    = 1'b1;
        rd_n_d    = 1'b1;
        wr_n_d    = 1'b1;
        ad_n_d    = 1'b1;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        unique case (state_d)
            ADDR: begin
                cs_n_d    = 1'b0;
                wr_n_d    = 1'b0;
                ad_n_d    = 1'b0;
                bus_oe_d  = 1'b1;
                bus_out_d = addr_sel;
                busy_d    = 1'b1;
            end
            GAP1, GAP2: busy_d = 1'b1;
            DATA: begin
                cs_n_d = 1'b0;
                busy_d = 1'b1;
                if (mode_wr_d) begin
                    wr_n_d    = 1'b0;
                    bus_oe_d  = 1'b1;
                    bus_out_d = data_sel;
                end else begin
                    rd_n_d = 1'b0;
                end
            end
            DONE: done_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            ph       <= '0;
            idx      <= 2'd0;
            mode_wr  <= 1'b0;
            snap     <= '0;
            bus_out  <= 8'h00;
            bus_oe   <= 1'b0;
            cs_n     <= 1'b1;
            rd_n     <= 1'b1;
            wr_n     <= 1'b1;
            ad_n     <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            seg_out  <= 8'h00;
            min_out  <= 8'h00;
            hora_out <= 8'h00;
        end else begin
            state   <= state_d;
            ph      <= ph_d;
            idx     <= idx_d;
            mode_wr <= mode_wr_d;
            snap    <= snap_d;
            bus_out <= bus_out_d;
            bus_oe  <= bus_oe_d;
            cs_n    <= cs_n_d;
            rd_n    <= rd_n_d;
            wr_n    <= wr_n_d;
            ad_n    <= ad_n_d;
            busy    <= busy_d;
            done    <= done_d;
            if (capture) begin
                unique case (idx)
                    2'd0:    seg_out  <= bus_in;
                    2'd1:    min_out  <= bus_in;
                    default: hora_out <= bus_in;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// Bench for rtc_bus_sequencer: directed and random sweeps checked against
// a cycle-index model of the bus protocol and a tiny RTC register file.
module tb_rtc_bus_sequencer;

    localparam int TP = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       start_read, start_write;
    logic [7:0] seg_in, min_in, hora_in;
    logic [7:0] bus_in;
    logic [7:0] bus_out;
    logic       bus_oe, cs_n, rd_n, wr_n, ad_n;
    logic [7:0] seg_out, min_out, hora_out;
    logic       busy, done;

    rtc_bus_sequencer #(.T_PH(TP)) dut (
        .clk(clk), .reset(reset),
        .start_read(start_read), .start_write(start_write),
        .seg_in(seg_in), .min_in(min_in), .hora_in(hora_in),
        .bus_in(bus_in), .bus_out(bus_out), .bus_oe(bus_oe),
        .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n), .ad_n(ad_n),
        .seg_out(seg_out), .min_out(min_out), .hora_out(hora_out),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // RTC chip model: latches the address phase, returns its register.
    logic [7:0] rtc_mem [256];
    logic [7:0] la = 8'h00;
    always @(posedge clk) if (!cs_n && !ad_n) la <= bus_out;
    assign bus_in = rtc_mem[la];

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_reg [3];
    logic [7:0] exp_bus;

    function automatic logic [7:0] addr_of(input int r);
        return (r == 0) ? 8'h21 : (r == 1) ? 8'h22 : 8'h23;
    endfunction

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic check_cycle(input string tag, input logic eoe, input logic ecs,
                               input logic erd, input logic ewr, input logic ead,
                               input logic ebusy, input logic edone);
        chk8({tag, ".bus_out"}, bus_out, exp_bus);
        chk1({tag, ".bus_oe"}, bus_oe, eoe);
        chk1({tag, ".cs_n"}, cs_n, ecs);
        chk1({tag, ".rd_n"}, rd_n, erd);
        chk1({tag, ".wr_n"}, wr_n, ewr);
        chk1({tag, ".ad_n"}, ad_n, ead);
        chk1({tag, ".busy"}, busy, ebusy);
        chk1({tag, ".done"}, done, edone);
        chk8({tag, ".seg_out"}, seg_out, exp_reg[0]);
        chk8({tag, ".min_out"}, min_out, exp_reg[1]);
        chk8({tag, ".hora_out"}, hora_out, exp_reg[2]);
    endtask

    // Starts a sweep from IDLE and checks every cycle through DONE and the
    // following IDLE cycle; abort_at>0 applies reset after that sweep cycle.
    task automatic run_sweep(input bit sr, input bit sw, input bit noise, input int abort_at);
        bit wr;
        logic [7:0] snap [3];
        int r, p;
        logic eoe, ecs, erd, ewr, ead;
        start_read  = sr;
        start_write = sw;
        @(posedge clk); #1;
        wr = sw;
        snap[0] = seg_in;
        snap[1] = min_in;
        snap[2] = hora_in;
        start_read  = 1'b0;
        start_write = 1'b0;
        if (!noise) begin
            seg_in = 8'h00; min_in = 8'h00; hora_in = 8'h00;
        end
        for (int k = 1; k <= 12*TP + 1; k++) begin
            if (k > 1) begin
                @(posedge clk); #1;
            end
            if (k <= 12*TP) begin
                r = (k - 1) / (4*TP);
                p = ((k - 1) / TP) % 4;
                eoe = 1'b0; ecs = 1'b1; erd = 1'b1; ewr = 1'b1; ead = 1'b1;
                if (p == 0) begin
                    ecs = 1'b0; ewr = 1'b0; ead = 1'b0; eoe = 1'b1;
                    exp_bus = addr_of(r);
                end else if (p == 2) begin
                    ecs = 1'b0;
                    if (wr) begin
                        ewr = 1'b0; eoe = 1'b1; exp_bus = snap[r];
                    end else begin
                        erd = 1'b0;
                    end
                end else if (p == 3 && !wr && ((k - 1) % TP) == 0) begin
                    exp_reg[r] = rtc_mem[addr_of(r)];
                end
                check_cycle("sweep", eoe, ecs, erd, ewr, ead, 1'b1, 1'b0);
            end else begin
                check_cycle("done", 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
            end
            if (k == abort_at) begin
                reset = 1'b1;
                start_read = 1'b0;
                start_write = 1'b0;
                @(posedge clk); #1;
                exp_reg[0] = 8'h00; exp_reg[1] = 8'h00; exp_reg[2] = 8'h00;
                exp_bus = 8'h00;
                check_cycle("midreset", 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
                reset = 1'b0;
                @(posedge clk); #1;
                check_cycle("postreset", 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
                return;
            end
            if (noise) begin
                start_read  = 1'($urandom_range(0, 1));
                start_write = 1'($urandom_range(0, 1));
                seg_in  = 8'($urandom);
                min_in  = 8'($urandom);
                hora_in = 8'($urandom);
            end
        end
        start_read  = 1'b0;
        start_write = 1'b0;
        @(posedge clk); #1;
        check_cycle("idle", 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rtc_mem[i] = 8'h00;
        exp_reg[0] = 8'h00; exp_reg[1] = 8'h00; exp_reg[2] = 8'h00;
        exp_bus = 8'h00;
        reset = 1'b1;
        start_read = 1'b1;
        start_write = 1'b0;
        seg_in = 8'h00; min_in = 8'h00; hora_in = 8'h00;

        // Reset held two cycles with a pending read request
        @(posedge clk); #1;
        check_cycle("reset1", 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        @(posedge clk); #1;
        check_cycle("reset2", 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        reset = 1'b0;
        start_read = 1'b0;
        @(posedge clk); #1;
        check_cycle("idle0", 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);

        // Directed read sweep
        rtc_mem[8'h21] = 8'h45; rtc_mem[8'h22] = 8'h30; rtc_mem[8'h23] = 8'h12;
        run_sweep(1'b1, 1'b0, 1'b0, 0);
        chk8("read.seg", seg_out, 8'h45);
        chk8("read.min", min_out, 8'h30);
        chk8("read.hora", hora_out, 8'h12);

        // Directed write sweep, inputs cleared right after start
        seg_in = 8'h59; min_in = 8'h07; hora_in = 8'h23;
        run_sweep(1'b0, 1'b1, 1'b0, 0);

        // Simultaneous requests: write wins
        seg_in = 8'h11; min_in = 8'h22; hora_in = 8'h33;
        run_sweep(1'b1, 1'b1, 1'b0, 0);

        // Read with start pulses and input churn during the sweep
        rtc_mem[8'h21] = 8'h58; rtc_mem[8'h22] = 8'h41; rtc_mem[8'h23] = 8'h09;
        run_sweep(1'b1, 1'b0, 1'b1, 0);

        // Reset at cycle 20 of a read, then a clean read
        rtc_mem[8'h21] = 8'h45; rtc_mem[8'h22] = 8'h30; rtc_mem[8'h23] = 8'h12;
        run_sweep(1'b1, 1'b0, 1'b0, 20);
        run_sweep(1'b1, 1'b0, 1'b0, 0);

        // Random sweeps
        for (int n = 0; n < 10; n++) begin
            int unsigned m;
            m = $urandom_range(1, 3);
            rtc_mem[8'h21] = 8'($urandom);
            rtc_mem[8'h22] = 8'($urandom);
            rtc_mem[8'h23] = 8'($urandom);
            seg_in  = 8'($urandom);
            min_in  = 8'($urandom);
            hora_in = 8'($urandom);
            run_sweep(m[0], m[1], 1'($urandom_range(0, 1)), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rtc_bus_sequencer.md
Name: rtc_bus_sequencer

Overview:
- Sequences the 8-bit multiplexed address/data bus of the RTC chip.
- On command, performs a 3-register sweep (seconds, minutes, hours), either reading into held 8-bit output registers or writing from snapshot inputs.
- Sits between the top-level controller FSM and the RTC pins; the display path consumes seg_out/min_out/hora_out.

Parameters:
- T_PH, 4, clock cycles per bus phase (>=1).
- ADDR_SEG, 8'h21, RTC address of seconds register.
- ADDR_MIN, 8'h22, RTC address of minutes register.
- ADDR_HORA, 8'h23, RTC address of hours register.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- start_read  input  1  request read sweep; sampled only in IDLE.
- start_write  input  1  request write sweep; sampled only in IDLE.
- seg_in  input  8  BCD seconds to write.
- min_in  input  8  BCD minutes to write.
- hora_in  input  8  BCD hours to write.
- bus_in  input  8  data from RTC pins.
- bus_out  output  8  value driven onto RTC pins.
- bus_oe  output  1  1 = drive bus_out onto pins.
- cs_n  output  1  chip select, active low.
- rd_n  output  1  read strobe, active low.
- wr_n  output  1  write strobe, active low.
- ad_n  output  1  0 = address phase, 1 = data phase.
- seg_out  output  8  last seconds read.
- min_out  output  8  last minutes read.
- hora_out  output  8  last hours read.
- busy  output  1  sweep in progress.
- done  output  1  one-cycle pulse at end of sweep.

Behaviour:
- Reset values: bus_out=0, bus_oe=0, cs_n=1, rd_n=1, wr_n=1, ad_n=1, seg_out=min_out=hora_out=0, busy=0, done=0. State=IDLE, index=0. All outputs are registered.
- States: IDLE, ADDR, GAP1, DATA, GAP2, DONE. Each of ADDR/GAP1/DATA/GAP2 lasts exactly T_PH cycles, counted by a phase counter.
- IDLE:
  - start_write=1 -> latch seg_in/min_in/hora_in into a snapshot, set mode=WRITE, go to ADDR.
  - Else start_read=1 -> mode=READ, go to ADDR.
  - Both high at once: write wins.
- Register index sequence: 0=ADDR_SEG, 1=ADDR_MIN, 2=ADDR_HORA.
- ADDR: cs_n=0, wr_n=0, rd_n=1, ad_n=0, bus_oe=1, bus_out=address[index].
- GAP1 and GAP2: cs_n=1, rd_n=1, wr_n=1, ad_n=1, bus_oe=0. bus_out holds its value.
- DATA, READ mode: cs_n=0, rd_n=0, wr_n=1, ad_n=1, bus_oe=0.
  - bus_in is sampled on the last DATA cycle.
  - The matching output register updates at that edge.
- DATA, WRITE mode: cs_n=0, wr_n=0, rd_n=1, ad_n=1, bus_oe=1, bus_out=snapshot[index].
  - Output registers are unchanged.
- End of GAP2:
  - index<2 -> index+1, go to ADDR.
  - index==2 -> go to DONE.
- DONE (1 cycle): done=1, busy=0, strobes inactive, then IDLE with index=0.
- busy=1 in every ADDR/GAP1/DATA/GAP2 cycle, 0 in IDLE and DONE.
- Timing:
  - Start sampled at edge E0 -> first ADDR cycle follows E0.
  - Sweep occupies 12*T_PH cycles.
  - done is high in cycle 12*T_PH+1 after E0.
- Output registers hold between sweeps. A write sweep never alters them.
- start_read/start_write are ignored while busy or in DONE; they are not queued.
- Snapshot inputs changing mid-sweep have no effect.
- Reset asserted mid-sweep:
  - Next edge returns to IDLE with all reset values.
  - No done pulse.
  - Partial read results are cleared to 0.
- Phase counter width is $clog2(T_PH)+1; T_PH=1 must work (ADDR, GAP1, DATA, GAP2 each 1 cycle).

Test Plan:
- Reset: assert reset 2 cycles with start_read=1 -> all outputs at reset values, busy stays 0, no bus activity.
- Read sweep, T_PH=4: bus model returns 8'h45/8'h30/8'h12 for addresses 21/22/23 -> ADDR-phase bus_out shows 21,22,23 in order; seg_out=45, min_out=30, hora_out=12; busy high 48 cycles; done pulse exactly 49 cycles after start edge.
- Write sweep: seg_in=59, min_in=07, hora_in=23, start_write pulse; change inputs to 0 the next cycle -> DATA phases drive 59,07,23 with bus_oe=1, wr_n=0; read outputs unchanged; done after 49 cycles.
- Simultaneous start_read=start_write=1 in IDLE -> write sweep performed (wr_n low in DATA, rd_n never low).
- Start pulses during a sweep (cycles 5 and 30) -> ignored; exactly one done; IDLE afterwards with no second sweep.
- Reset at cycle 20 of a read sweep (after seg_out captured) -> next cycle IDLE, cs_n=1, seg_out=0, no done; a fresh start_read then completes normally.
